// File: rtl/interfaz_uart_regs.sv
// interfaz_uart_regs: register-mapped 8N1 UART with TX/RX byte buffers and one control register.
// Define UART_LOOPBACK_EN to feed the RX synchroniser from tx_o instead of rx_i.
`timescale 1ns/1ps
module interfaz_uart_regs #(
  parameter int BAUD_DIV = 10417,
  parameter int BUF_AW   = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_i,
  input  logic        reg_sel_i,
  input  logic [31:0] entrada_i,
  input  logic [31:0] addr_i,
  output logic [31:0] salida_o,
  output logic        tx_o,
  input  logic        rx_i
);
  localparam int DEPTH = 1 << BUF_AW;
  localparam int CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_NEXT} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  logic [7:0] txbuf [DEPTH];
  logic [7:0] rxbuf [DEPTH];

  tx_state_e         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [BUF_AW-1:0] tx_idx_q, tx_idx_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_q, tx_d;
  logic              tx_done;

  rx_state_e         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [BUF_AW-1:0] rx_ptr_q, rx_ptr_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic              rx_src;
  logic              rx_store, rx_ferr;

  logic              send_q, send_d;
  logic              rx_new_q, rx_new_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        last_idx_q, last_idx_d;
  logic [31:0]       salida_q, salida_d;
  logic [31:0]       ctrl_word;
  logic              ctrl_wr;
  logic              unused_bits;

  assign unused_bits = ^{entrada_i[31:12], entrada_i[3], addr_i[31:BUF_AW]};

`ifdef UART_LOOPBACK_EN
  logic unused_rx;
  assign rx_src    = tx_q;
  assign unused_rx = rx_i;
`else
  assign rx_src = rx_i;
`endif

  assign tx_o     = tx_q;
  assign salida_o = salida_q;
  assign ctrl_wr  = wr_i && !reg_sel_i;
  assign ctrl_word = {12'b0, 8'(rx_ptr_q), last_idx_q, 1'b0, frame_err_q, rx_new_q, send_q};

  // TX: the next byte is fetched in T_NEXT, so late buffer writes are still picked up.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done    = 1'b0;
    unique case (tx_state_q)
      T_IDLE: begin
        if (send_q) begin
          tx_idx_d   = '0;
          tx_shift_d = txbuf[{BUF_AW{1'b0}}];
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_NEXT;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      T_NEXT: begin
        if (tx_idx_q == BUF_AW'(last_idx_q)) begin
          tx_done    = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          tx_idx_d   = tx_idx_q + BUF_AW'(1);
          tx_shift_d = txbuf[tx_idx_d];
          tx_d       = 1'b0;
          tx_state_d = T_START;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ptr_d   = rx_ptr_q;
    rx_store   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (rx_sync_q) begin
            rx_store = 1'b1;
            rx_ptr_d = rx_ptr_q + BUF_AW'(1);
          end else begin
            rx_ferr = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Hardware sets of rx_new/frame_err take priority over a same-cycle software clear.
  always_comb begin
    send_d      = send_q;
    last_idx_d  = last_idx_q;
    rx_new_d    = rx_new_q;
    frame_err_d = frame_err_q;
    salida_d    = salida_q;
    if (ctrl_wr && tx_state_q == T_IDLE) begin
      send_d     = entrada_i[0];
      last_idx_d = entrada_i[11:4];
    end
    if (tx_done) send_d = 1'b0;
    if (ctrl_wr && !entrada_i[1]) rx_new_d = 1'b0;
    if (rx_store) rx_new_d = 1'b1;
    if (ctrl_wr && !entrada_i[2]) frame_err_d = 1'b0;
    if (rx_ferr) frame_err_d = 1'b1;
    if (!wr_i) salida_d = reg_sel_i ? {24'b0, rxbuf[addr_i[BUF_AW-1:0]]} : ctrl_word;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tx_state_q  <= T_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_ptr_q    <= '0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      send_q      <= 1'b0;
      rx_new_q    <= 1'b0;
      frame_err_q <= 1'b0;
      last_idx_q  <= '0;
      salida_q    <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_ptr_q    <= rx_ptr_d;
      rx_meta_q   <= rx_src;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      send_q      <= send_d;
      rx_new_q    <= rx_new_d;
      frame_err_q <= frame_err_d;
      last_idx_q  <= last_idx_d;
      salida_q    <= salida_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_i && reg_sel_i) txbuf[addr_i[BUF_AW-1:0]] <= entrada_i[7:0];
    if (rx_store) rxbuf[rx_ptr_q] <= rx_shift_q;
  end

endmodule
